// File: rtl/axis_reg_pkg.sv
// Shared types and field layout for the framed AXI4-Stream test-word source.
package axis_reg_pkg;

    localparam int AXIS_DATA_W = 32;

    localparam int FRAME_MSB = 31;
    localparam int FRAME_LSB = 16;
    localparam int BEAT_MSB  = 15;
    localparam int BEAT_LSB  = 0;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid-buffer register slice: full throughput, all outputs from flops,
// and the upstream ready is itself a flop.
module axis_reg_slice
    import axis_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  axis_beat_t s_beat,
    input  logic       s_valid,
    output logic       s_ready,
    output axis_beat_t m_beat,
    output logic       m_valid,
    input  logic       m_ready
);

    axis_beat_t out_beat_reg, out_beat_next;
    logic       out_valid_reg, out_valid_next;
    axis_beat_t skid_beat_reg, skid_beat_next;
    logic       skid_valid_reg, skid_valid_next;

    always_comb begin
        out_beat_next   = out_beat_reg;
        out_valid_next  = out_valid_reg;
        skid_beat_next  = skid_beat_reg;
        skid_valid_next = skid_valid_reg;
        if (m_ready || !out_valid_reg) begin
            // Output slot frees up: drain the skid entry first to keep ordering.
            if (skid_valid_reg) begin
                out_beat_next   = skid_beat_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = s_valid;
                if (s_valid) begin
                    out_beat_next = s_beat;
                end
            end
        end else if (s_valid && !skid_valid_reg) begin
            skid_beat_next  = s_beat;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_beat_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_beat_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            out_beat_reg   <= out_beat_next;
            out_valid_reg  <= out_valid_next;
            skid_beat_reg  <= skid_beat_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign s_ready = !skid_valid_reg;
    assign m_beat  = out_beat_reg;
    assign m_valid = out_valid_reg;

endmodule

// File: rtl/axis_reg_top.sv
// Free-running framed test-word generator ({frame_idx, beat_idx}) driven onto
// an AXI4-Stream master port through a skid-buffer register slice.
module axis_reg_top
    import axis_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAME_LEN  = 16,
    parameter int NUM_FRAMES = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam logic [15:0] LAST_BEAT  = 16'(FRAME_LEN - 1);
    localparam logic [31:0] LAST_FRAME = 32'(NUM_FRAMES - 1);

    logic [15:0] beat_idx_reg, beat_idx_next;
    logic [15:0] frame_idx_reg, frame_idx_next;
    logic [31:0] frames_done_reg, frames_done_next;
    logic        done_reg, done_next;

    logic        gen_valid;
    logic        gen_ready;
    logic        gen_last;
    logic        gen_fire;
    logic [AXIS_DATA_W-1:0] gen_word;
    axis_beat_t  gen_beat;
    axis_beat_t  out_beat;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word
            assign gen_word[FRAME_LSB + gi] = frame_idx_reg[gi];
            assign gen_word[BEAT_LSB + gi]  = beat_idx_reg[gi];
        end
    endgenerate

    assign gen_valid = !done_reg;
    assign gen_last  = (beat_idx_reg == LAST_BEAT);
    assign gen_fire  = gen_valid && gen_ready;
    assign gen_beat  = '{data: gen_word, last: gen_last};

    always_comb begin
        beat_idx_next    = beat_idx_reg;
        frame_idx_next   = frame_idx_reg;
        frames_done_next = frames_done_reg;
        done_next        = done_reg;
        if (gen_fire) begin
            if (gen_last) begin
                beat_idx_next    = '0;
                frame_idx_next   = frame_idx_reg + 16'd1;
                frames_done_next = frames_done_reg + 32'd1;
                // Bounded run: stop handing beats to the slice after the final frame.
                if ((NUM_FRAMES != 0) && (frames_done_reg == LAST_FRAME)) begin
                    done_next = 1'b1;
                end
            end else begin
                beat_idx_next = beat_idx_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_idx_reg    <= '0;
            frame_idx_reg   <= '0;
            frames_done_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            beat_idx_reg    <= beat_idx_next;
            frame_idx_reg   <= frame_idx_next;
            frames_done_reg <= frames_done_next;
            done_reg        <= done_next;
        end
    end

    axis_reg_slice u_slice (
        .clk     (clk),
        .reset   (reset),
        .s_beat  (gen_beat),
        .s_valid (gen_valid),
        .s_ready (gen_ready),
        .m_beat  (out_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tlast = out_beat.last;

endmodule

// File: tb/tb_axis_reg_top.sv
// Scoreboard bench for axis_reg_top: free-running, bounded-run and single-beat-frame builds.
module tb_axis_reg_top;
    import axis_reg_pkg::*;

    logic        clk;
    logic        rstn   [3];
    logic        rdy    [3];
    logic [31:0] tdata  [3];
    logic        tvalid [3];
    logic        tlast  [3];

    int vectors     = 0;
    int miscompares = 0;

    axis_beat_t sb[$];
    int mf, mb, fl;

    axis_reg_top #(.DATA_W(32), .FRAME_LEN(16), .NUM_FRAMES(0)) u_free (
        .clk(clk), .reset(rstn[0]), .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]),
        .m_axis_tready(rdy[0]), .m_axis_tlast(tlast[0]));

    axis_reg_top #(.DATA_W(32), .FRAME_LEN(4), .NUM_FRAMES(2)) u_bounded (
        .clk(clk), .reset(rstn[1]), .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]),
        .m_axis_tready(rdy[1]), .m_axis_tlast(tlast[1]));

    axis_reg_top #(.DATA_W(32), .FRAME_LEN(1), .NUM_FRAMES(0)) u_len1 (
        .clk(clk), .reset(rstn[2]), .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]),
        .m_axis_tready(rdy[2]), .m_axis_tlast(tlast[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_start(input int frame_len);
        sb.delete();
        mf = 0;
        mb = 0;
        fl = frame_len;
    endfunction

    function automatic void push(input int n);
        axis_beat_t e;
        for (int i = 0; i < n; i++) begin
            e.data = {mf[15:0], mb[15:0]};
            e.last = (mb == fl - 1);
            sb.push_back(e);
            if (e.last) begin
                mb = 0;
                mf = (mf + 1) & 32'hFFFF;
            end else begin
                mb = mb + 1;
            end
        end
    endfunction

    task automatic xfer(input int d, input bit r, output bit fired);
        axis_beat_t e;
        @(negedge clk);
        rdy[d] = r;
        fired = 1'b0;
        if (tvalid[d] === 1'b1 && r) begin
            fired = 1'b1;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra dut%0d: got %h last=%0b, required no beat", d, tdata[d], tlast[d]);
            end else begin
                e = sb.pop_front();
                if (tdata[d] !== e.data || tlast[d] !== e.last) begin
                    miscompares++;
                    $display("FAIL beat dut%0d: got %h last=%0b, required %h last=%0b",
                             d, tdata[d], tlast[d], e.data, e.last);
                end
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0;
            rdy[d]  = 1'b0;
        end
        rdy[0] = 1'b1;
        #3;
        for (int d = 0; d < 3; d++) begin
            check_word("reset_tdata", tdata[d], 32'h0);
            check_bit("reset_tvalid", tvalid[d], 1'b0);
            check_bit("reset_tlast", tlast[d], 1'b0);
        end
        #3;
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
        @(negedge clk);
        check_bit("latency_tvalid_before_edge", tvalid[0], 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_first_frame();
        bit f;
        model_start(16);
        push(21);
        for (int i = 0; i < 21; i++) begin
            xfer(0, 1'b1, f);
            check_bit("no_gap", f, 1'b1);
            $display("first_frame beat %0d tdata=%h tlast=%0b", i, tdata[0], tlast[0]);
        end
    endtask

    task automatic test_backpressure();
        bit f;
        push(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdy[0] = 1'b0;
            check_bit("hold_tvalid", tvalid[0], 1'b1);
            check_word("hold_tdata", tdata[0], sb[0].data);
            check_bit("hold_tlast", tlast[0], sb[0].last);
            $display("backpressure cycle %0d tdata=%h", i, tdata[0]);
        end
        for (int i = 0; i < 2; i++) begin
            xfer(0, 1'b1, f);
            check_bit("resume_fire", f, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        bit f;
        push(16);
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b1, f);
            check_bit("advance_fire", f, 1'b1);
        end
        @(negedge clk);
        rdy[0] = 1'b0;
        check_word("pre_reset_tdata", tdata[0], 32'h0002_0007);
        #2 rstn[0] = 1'b0;
        #1;
        check_word("async_tdata", tdata[0], 32'h0);
        check_bit("async_tvalid", tvalid[0], 1'b0);
        check_bit("async_tlast", tlast[0], 1'b0);
        @(negedge clk);
        check_bit("held_in_reset_tvalid", tvalid[0], 1'b0);
        #1 rstn[0] = 1'b1;
        model_start(16);
        push(3);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, f);
            check_bit("restart_fire", f, 1'b1);
            $display("restart beat %0d tdata=%h", i, tdata[0]);
        end
    endtask

    task automatic test_alternating();
        bit f;
        int n = 0;
        push(20);
        for (int i = 0; i < 40; i++) begin
            xfer(0, (i % 2) == 0, f);
            if (f) $display("alternating xfer tdata=%h tlast=%0b", tdata[0], tlast[0]);
            n += int'(f);
        end
        check_word("alternating_count", n, 32'd20);
        check_word("alternating_sb_left", sb.size(), 32'd0);
    endtask

    task automatic test_num_frames();
        bit f;
        int n = 0;
        model_start(4);
        push(8);
        for (int i = 0; i < 50 && n < 8; i++) begin
            xfer(1, 1'b1, f);
            if (f) $display("bounded xfer tdata=%h tlast=%0b", tdata[1], tlast[1]);
            n += int'(f);
        end
        check_word("bounded_count", n, 32'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_bit("stopped_tvalid", tvalid[1], 1'b0);
        end
        check_word("stopped_tdata_hold", tdata[1], 32'h0001_0003);
        check_bit("stopped_tlast_hold", tlast[1], 1'b1);
    endtask

    task automatic test_frame_len1();
        bit f;
        model_start(1);
        push(3);
        for (int i = 0; i < 3; i++) begin
            xfer(2, 1'b1, f);
            check_bit("len1_fire", f, 1'b1);
            $display("len1 xfer tdata=%h tlast=%0b", tdata[2], tlast[2]);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_backpressure();
        test_reset_mid();
        test_alternating();
        test_num_frames();
        test_frame_len1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
